// File: rtl/strb_serializer.sv
// Strobe-paced serializer: takes one word over valid/ready and shifts it out one bit per divider strobe inside an active-low cs_n frame.
// Optional even-parity trailer bit is enabled by defining STRB_SERIALIZER_PARITY_EN.
module strb_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strb_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              div_en_o,
  output logic              sdo_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

`ifdef STRB_SERIALIZER_PARITY_EN
  localparam int FRAME_N = DATA_W + 1;
`else
  localparam int FRAME_N = DATA_W;
`endif
  // The counter holds the index of the bit currently on sdo_o, so it tops out at FRAME_N-1.
  localparam int CNT_W = (FRAME_N > 2) ? $clog2(FRAME_N) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_N - 1);
`ifdef STRB_SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [CNT_W-1:0]  cnt_q;
`ifdef STRB_SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  logic              strb_evt;
  logic              head_bit;
  logic [DATA_W-1:0] sr_next;

  // Handshake: a word transfers on any clk_i edge where s_valid_i and s_ready_o are both high;
  // s_ready_o is high only in IDLE and s_valid_i is not required to stay up once ready drops.
  assign s_ready_o = (state_q == IDLE);
  assign busy_o    = (state_q != IDLE);
  assign state_o   = state_q;

  // The divider's strobe is meaningless while we hold it disabled.
  assign strb_evt = strb_i & div_en_o;

  always_comb begin
    head_bit = MSB_FIRST ? sr_q[DATA_W-1] : sr_q[0];
    sr_next  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      div_en_o <= 1'b0;
      cs_n_o   <= 1'b1;
      sdo_o    <= 1'b1;
      done_o   <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
`ifdef STRB_SERIALIZER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid_i) begin
            sr_q     <= s_data_i;
`ifdef STRB_SERIALIZER_PARITY_EN
            par_q    <= ^s_data_i;
`endif
            cnt_q    <= '0;
            div_en_o <= 1'b1;
            cs_n_o   <= 1'b0;
            state_q  <= LEAD;
          end
        end
        // The divider fires in its first enabled cycle, so this strobe starts bit 0.
        LEAD: begin
          if (strb_evt) begin
            sdo_o   <= head_bit;
            sr_q    <= sr_next;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (strb_evt) begin
            if (cnt_q == LAST_IDX) begin
              sdo_o   <= 1'b1;
              state_q <= STOP;
            end
`ifdef STRB_SERIALIZER_PARITY_EN
            else if (cnt_q == PAR_IDX) begin
              sdo_o <= par_q;
              cnt_q <= cnt_q + 1'b1;
            end
`endif
            else begin
              sdo_o <= head_bit;
              sr_q  <= sr_next;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (strb_evt) begin
            cs_n_o   <= 1'b1;
            div_en_o <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/strb_serializer.md
Name: strb_serializer

Overview:
- Downstream consumer of the divide-by-3 clock divider's strobe output.
- Accepts parallel words over a valid/ready handshake and shifts them out serially, one bit per divider strobe, framed by an active-low chip select.
- Owns the divider's enable: asserts it for the duration of a frame and releases it when idle, so the divider counters restart aligned to each frame.

Parameters:
- DATA_W, 8: payload bits per frame (2..32).
- MSB_FIRST, 1: 1 = transmit bit DATA_W-1 first; 0 = bit 0 first.

Ports:
- clk_i  input  1  system clock; same clock as the divider.
- rst_i  input  1  synchronous, active-high reset.
- strb_i  input  1  bit-rate strobe from the divider. One clk_i cycle wide. Used only while div_en_o=1.
- s_data_i  input  DATA_W  payload word.
- s_valid_i  input  1  payload valid.
- s_ready_o  output  1  block can accept a word.
- div_en_o  output  1  enable to the divider, registered.
- sdo_o  output  1  serial data out, registered; idles at 1.
- cs_n_o  output  1  frame select, active low, registered.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse in the first IDLE cycle after a frame.

Behaviour:
- Reset values (at the clock edge where rst_i=1):
  - state = IDLE.
  - div_en_o=0, cs_n_o=1, sdo_o=1, done_o=0.
  - Shift register and bit counter = 0.
  - Reset has priority over everything, including in the middle of a frame. The frame is abandoned with no done_o.
- Frame length N = DATA_W (DATA_W+1 with PARITY_EN).
- s_ready_o = (state==IDLE), combinational. Accept occurs when s_valid_i & s_ready_o.
- State machine, one state register:
  - IDLE:
    - cs_n_o=1, sdo_o=1, div_en_o=0. strb_i ignored.
    - On accept: latch s_data_i into the shift register, bit counter = 0, div_en_o<=1, cs_n_o<=0, go to LEAD.
  - LEAD:
    - First strobe after enable aligns the frame. The divider emits a strobe in the first enabled cycle.
    - On strb_i: sdo_o <= first bit, go to SHIFT.
  - SHIFT:
    - On strb_i: if counter == N-1, then sdo_o<=1 and go to STOP.
    - Otherwise sdo_o <= next bit and counter++.
  - STOP:
    - One strobe period of idle level with cs_n_o still low.
    - On strb_i: cs_n_o<=1, div_en_o<=0, done_o<=1, go to IDLE.
- done_o is high for exactly one cycle, then clears.
- Bit order:
  - MSB_FIRST=1: shift left and send the MSB.
  - MSB_FIRST=0: shift right and send the LSB.
- Timing with the divide-by-3 divider (strobe every 3 cycles), accept at edge of cycle T0, DATA_W=8:
  - LEAD at T1 with strb at T1.
  - Bit k valid T(2+3k)..T(4+3k); bit 7 valid T23..T25.
  - sdo_o=1 from T26.
  - STOP strobe at T28.
  - T29: IDLE, cs_n_o=1, done_o=1, s_ready_o=1.
  - Accept to done = 29 cycles. Generally 3N+5.
- Boundary conditions:
  - s_valid_i while busy: ignored, not queued.
  - s_data_i is sampled only at accept; later changes have no effect.
  - Back-to-back: a word offered during the done_o cycle is accepted that cycle. cs_n_o is therefore high for at least 1 cycle between frames.
  - strb_i with div_en_o=0: ignored.
  - Strobe period is arbitrary (>=1 cycle). If strb_i is held high continuously, one event is counted per cycle.

Optional Feature:
- Macro: STRB_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the latched word) is sent as frame bit N-1 = DATA_W, after the payload and before STOP.
  - N = DATA_W+1; accept-to-done latency becomes 3N+5 with the divide-by-3 divider.
- Undefined:
  - No parity logic; N = DATA_W.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with s_valid_i=1 -> s_ready_o=1, cs_n_o=1, sdo_o=1, div_en_o=0, done_o=0, no accept while rst_i=1.
- Single frame, divide-by-3 model, MSB_FIRST=1, word 0xA5 accepted at T0:
  - cs_n_o low T1..T28.
  - sdo_o = 1,0,1,0,0,1,0,1, each bit held 3 cycles starting T2.
  - done_o=1 at T29 only.
- MSB_FIRST=0 with word 0x01 -> first bit sent is 1, next 7 bits are 0.
- Back-to-back: words 0x3C then 0xC3 presented continuously -> second accept in the done_o cycle of the first, cs_n_o high exactly 1 cycle, both frames bit-exact.
- Mid-frame reset: rst_i=1 at T10 of a frame -> at T11 cs_n_o=1, div_en_o=0, sdo_o=1, no done_o. A new frame afterwards is bit-exact.
- PARITY_EN with 0x07 -> 9th bit = 1, done at T32. With 0x03 -> 9th bit = 0.
